// File: rtl/debounce_pkg.sv
// Shared types and constants for the asynchronous input debouncer.
package debounce_pkg;

   typedef enum logic {ST_STABLE, ST_CHECK} db_state_t;

   localparam int GLITCH_W        = 8;
   localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer for a single-bit level crossing into clk.
module sync_chain
   import debounce_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_d;
   logic [STAGES-1:0] sync_q;

   if (STAGES < MIN_SYNC_STAGES) begin : g_stage_check
      $error("sync_chain: STAGES must be at least %0d", MIN_SYNC_STAGES);
   end

   // Pure shift: no logic between stages so each flop has a full period to resolve
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_input_debouncer.sv
// Synchronizes an asynchronous level, accepts it only after STABLE_CYCLES
// consistent samples, emits edge pulses and counts rejected glitches.
module async_input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                D,
   output logic                Q,
   output logic                rise,
   output logic                fall,
   output logic [GLITCH_W-1:0] glitches
);

   localparam int unsigned         CNT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   if (SYNC_STAGES < MIN_SYNC_STAGES || STABLE_CYCLES < 1) begin : g_param_check
      $error("async_input_debouncer: need SYNC_STAGES >= %0d and STABLE_CYCLES >= 1",
             MIN_SYNC_STAGES);
   end

   logic                d_sync;
   db_state_t           state_d, state_q;
   logic [CNT_W-1:0]    cnt_d, cnt_q;
   logic                q_d, q_q;
   logic                rise_d, rise_q;
   logic                fall_d, fall_q;
   logic [GLITCH_W-1:0] glitches_d, glitches_q;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (D),
      .q     (d_sync)
   );

   // Stability check: a change must persist STABLE_CYCLES samples to reach Q
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      q_d        = q_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      glitches_d = glitches_q;

      case (state_q)
         ST_STABLE: begin
            cnt_d = '0;
            if (d_sync != q_q) begin
               if (STABLE_CYCLES == 1) begin
                  q_d    = d_sync;
                  rise_d = d_sync;
                  fall_d = ~d_sync;
               end else begin
                  state_d = ST_CHECK;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_CHECK: begin
            if (d_sync == q_q) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
               if (glitches_q != GLITCH_MAX) begin
                  glitches_d = glitches_q + GLITCH_W'(1);
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
               q_d     = d_sync;
               rise_d  = d_sync;
               fall_d  = ~d_sync;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_STABLE;
         cnt_q      <= '0;
         q_q        <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         glitches_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         q_q        <= q_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         glitches_q <= glitches_d;
      end
   end

   assign Q        = q_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign glitches = glitches_q;

endmodule

// File: tb/tb_async_input_debouncer.sv
// Scenario bench for async_input_debouncer: default instance plus a
// SYNC_STAGES=3 / STABLE_CYCLES=1 instance driven with random timing.
`timescale 1ns/1ps
module tb_async_input_debouncer;

   typedef struct {
      logic is_rise;
      int   edge_no;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       d_a   = 1'b0;
   logic       d_b   = 1'b0;
   logic       q_a, rise_a, fall_a;
   logic       q_b, rise_b, fall_b;
   logic [7:0] glitches_a, glitches_b;

   int   total      = 0;
   int   bad        = 0;
   int   cyc        = 0;
   int   exp_glitch = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];

   always #5 clk = ~clk;

   async_input_debouncer dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .D        (d_a),
      .Q        (q_a),
      .rise     (rise_a),
      .fall     (fall_a),
      .glitches (glitches_a)
   );

   async_input_debouncer #(
      .SYNC_STAGES   (3),
      .STABLE_CYCLES (1)
   ) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .D        (d_b),
      .Q        (q_b),
      .rise     (rise_b),
      .fall     (fall_b),
      .glitches (glitches_b)
   );

   // Advance one rising edge and settle; cyc numbers the edge just taken
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      exp_t e;
      int   start;
      rst_n = 1'b0;
      d_a   = 1'b1;
      #12;
      total++;
      if (q_a !== 1'b0) begin
         bad++; $display("FAIL reset_q: got %b want 0", q_a);
      end
      total++;
      if ({rise_a, fall_a} !== 2'b00) begin
         bad++; $display("FAIL reset_pulses: got rise=%b fall=%b want 0 0", rise_a, fall_a);
      end
      total++;
      if (glitches_a !== 8'd0) begin
         bad++; $display("FAIL reset_glitches: got %0d want 0", glitches_a);
      end
      total++;
      if (q_b !== 1'b0) begin
         bad++; $display("FAIL reset_q_b: got %b want 0", q_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start = cyc;
      sb_a.push_back('{is_rise: 1'b1, edge_no: start + 6});
      for (int i = 1; i <= 8; i++) begin
         tick();
         total++;
         if (q_a !== (i >= 6)) begin
            bad++; $display("FAIL release_q: edge %0d got %b want %b", i, q_a, (i >= 6));
         end
         if (rise_a || fall_a) begin
            total++;
            if (sb_a.size() == 0) begin
               bad++; $display("FAIL release_pulse: unexpected rise=%b fall=%b at edge %0d", rise_a, fall_a, cyc);
            end else begin
               e = sb_a.pop_front();
               if (rise_a !== e.is_rise || fall_a !== !e.is_rise || cyc != e.edge_no) begin
                  bad++; $display("FAIL release_pulse: got rise=%b fall=%b at edge %0d want rise=%b at edge %0d",
                                  rise_a, fall_a, cyc, e.is_rise, e.edge_no);
               end
            end
         end
      end
      total++;
      if (glitches_a !== 8'd0) begin
         bad++; $display("FAIL release_glitches: got %0d want 0", glitches_a);
      end
      total++;
      if (sb_a.size() != 0) begin
         bad++; $display("FAIL release_missing: %0d pulses outstanding want 0", sb_a.size());
         sb_a.delete();
      end
   endtask

   task automatic test_clean_edges();
      exp_t e;
      logic lvl;
      int   start;
      for (int k = 0; k < 3; k++) begin
         lvl   = (k == 1);
         d_a   = lvl;
         start = cyc;
         sb_a.push_back('{is_rise: lvl, edge_no: start + 6});
         for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (q_a !== ((i >= 6) ? lvl : !lvl)) begin
               bad++; $display("FAIL clean_q: step %0d edge %0d got %b want %b", k, i, q_a, ((i >= 6) ? lvl : !lvl));
            end
            if (rise_a || fall_a) begin
               total++;
               if (sb_a.size() == 0) begin
                  bad++; $display("FAIL clean_pulse: unexpected rise=%b fall=%b at edge %0d", rise_a, fall_a, cyc);
               end else begin
                  e = sb_a.pop_front();
                  if (rise_a !== e.is_rise || fall_a !== !e.is_rise || cyc != e.edge_no) begin
                     bad++; $display("FAIL clean_pulse: got rise=%b fall=%b at edge %0d want rise=%b at edge %0d",
                                     rise_a, fall_a, cyc, e.is_rise, e.edge_no);
                  end
               end
            end
         end
         total++;
         if (sb_a.size() != 0) begin
            bad++; $display("FAIL clean_missing: step %0d, %0d pulses outstanding want 0", k, sb_a.size());
            sb_a.delete();
         end
      end
   endtask

   task automatic test_glitch();
      d_a = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 2) d_a = 1'b0;
         total++;
         if (q_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0) begin
            bad++; $display("FAIL glitch_outputs: edge %0d got q=%b rise=%b fall=%b want 0 0 0", i, q_a, rise_a, fall_a);
         end
         total++;
         if (glitches_a !== 8'(exp_glitch + ((i >= 5) ? 1 : 0))) begin
            bad++; $display("FAIL glitch_count: edge %0d got %0d want %0d", i, glitches_a, exp_glitch + ((i >= 5) ? 1 : 0));
         end
      end
      exp_glitch++;
   endtask

   task automatic test_saturation();
      logic pulse_seen = 1'b0;
      for (int n = 0; n < 300; n++) begin
         d_a = 1'b1;
         for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 2) d_a = 1'b0;
            if (rise_a || fall_a || q_a) pulse_seen = 1'b1;
         end
         exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
         total++;
         if (glitches_a !== 8'(exp_glitch)) begin
            bad++; $display("FAIL sat_count: glitch %0d got %0d want %0d", n, glitches_a, exp_glitch);
         end
      end
      total++;
      if (pulse_seen !== 1'b0) begin
         bad++; $display("FAIL sat_outputs: got q/pulse activity=%b want 0", pulse_seen);
      end
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (glitches_a !== 8'd255) begin
         bad++; $display("FAIL sat_hold: got %0d want 255", glitches_a);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   start;
      d_a   = 1'b1;
      start = cyc;
      sb_a.push_back('{is_rise: 1'b1, edge_no: start + 6});
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (rise_a || fall_a) begin
            total++;
            if (sb_a.size() == 0) begin
               bad++; $display("FAIL mid_pulse: unexpected rise=%b fall=%b at edge %0d", rise_a, fall_a, cyc);
            end else begin
               e = sb_a.pop_front();
               if (rise_a !== e.is_rise || fall_a !== !e.is_rise || cyc != e.edge_no) begin
                  bad++; $display("FAIL mid_pulse: got rise=%b fall=%b at edge %0d want rise=%b at edge %0d",
                                  rise_a, fall_a, cyc, e.is_rise, e.edge_no);
               end
            end
         end
      end
      total++;
      if (sb_a.size() != 0) begin
         bad++; $display("FAIL mid_missing: %0d pulses outstanding want 0", sb_a.size());
         sb_a.delete();
      end
      // Start a falling candidate so the FSM sits in its checking state
      d_a = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (q_a !== 1'b1) begin
         bad++; $display("FAIL mid_pre_q: got %b want 1", q_a);
      end
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (q_a !== 1'b0) begin
         bad++; $display("FAIL mid_reset_q: got %b want 0", q_a);
      end
      total++;
      if ({rise_a, fall_a} !== 2'b00) begin
         bad++; $display("FAIL mid_reset_pulses: got rise=%b fall=%b want 0 0", rise_a, fall_a);
      end
      total++;
      if (glitches_a !== 8'd0) begin
         bad++; $display("FAIL mid_reset_glitches: got %0d want 0", glitches_a);
      end
      exp_glitch = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      total++;
      if (q_a !== 1'b0 || glitches_a !== 8'd0) begin
         bad++; $display("FAIL mid_after: got q=%b glitches=%0d want 0 0", q_a, glitches_a);
      end
   endtask

   task automatic test_random();
      localparam int N = 30;
      fork
         begin : drive
            int t = 0;
            while (t < 100) begin
               int dl;
               dl = $urandom_range(11, 19);
               #(dl);
               t += dl;
               d_b = ~d_b;
            end
         end
         begin : sample
            logic prev;
            prev = d_b;
            for (int i = 0; i < N; i++) begin
               @(negedge clk);
               if (d_b !== prev) sb_b.push_back('{is_rise: d_b, edge_no: cyc + 3});
               prev = d_b;
            end
         end
         begin : check
            exp_t e;
            int   diff;
            for (int i = 0; i < N; i++) begin
               tick();
               total++;
               if (rise_b && fall_b) begin
                  bad++; $display("FAIL rand_both: rise and fall high at edge %0d", cyc);
               end
               total++;
               if (glitches_b !== 8'd0) begin
                  bad++; $display("FAIL rand_glitches: got %0d want 0", glitches_b);
               end
               if (rise_b || fall_b) begin
                  total++;
                  if (sb_b.size() == 0) begin
                     bad++; $display("FAIL rand_pulse: unexpected rise=%b fall=%b at edge %0d", rise_b, fall_b, cyc);
                  end else begin
                     e    = sb_b.pop_front();
                     diff = cyc - e.edge_no;
                     if (rise_b !== e.is_rise || diff < -1 || diff > 1) begin
                        bad++; $display("FAIL rand_pulse: got rise=%b at edge %0d want rise=%b at edge %0d +-1",
                                        rise_b, cyc, e.is_rise, e.edge_no);
                     end
                  end
               end
            end
         end
      join
      total++;
      if (sb_b.size() != 0) begin
         bad++; $display("FAIL rand_missing: %0d pulses outstanding want 0", sb_b.size());
         sb_b.delete();
      end
      total++;
      if (q_b !== d_b) begin
         bad++; $display("FAIL rand_final_q: got %b want %b", q_b, d_b);
      end
   endtask

   initial begin
      test_reset();
      test_clean_edges();
      test_glitch();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
